// File: rtl/exception_ctrl_pkg.sv
// Shared constants for the MEM-stage exception arbiter.
// Holds excepttype bit positions, CP0 register addresses, the default
// exception vector, mem_exc_i flag positions and the arbiter FSM state type.
package exception_ctrl_pkg;

   // excepttype_o bit positions (one-hot word handed to CP0)
   localparam int unsigned EXC_INT     = 0;
   localparam int unsigned EXC_SYSCALL = 8;
   localparam int unsigned EXC_BREAK   = 9;
   localparam int unsigned EXC_RI      = 10;
   localparam int unsigned EXC_ERET    = 12;
   localparam int unsigned EXC_ADEL_IF = 13;
   localparam int unsigned EXC_ADEL_LD = 14;
   localparam int unsigned EXC_ADES    = 15;
   localparam int unsigned EXC_OV      = 16;

   // CP0 register addresses
   localparam logic [4:0] CP0_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_COUNT    = 5'd9;
   localparam logic [4:0] CP0_COMPARE  = 5'd11;
   localparam logic [4:0] CP0_STATUS   = 5'd12;
   localparam logic [4:0] CP0_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_EPC      = 5'd14;

   localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

   // mem_exc_i flag positions
   localparam int unsigned F_ADEL_IF = 0;
   localparam int unsigned F_RI      = 1;
   localparam int unsigned F_OV      = 2;
   localparam int unsigned F_BREAK   = 3;
   localparam int unsigned F_SYSCALL = 4;
   localparam int unsigned F_ADEL_LD = 5;
   localparam int unsigned F_ADES    = 6;
   localparam int unsigned F_ERET    = 7;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

endpackage

// File: rtl/exception_ctrl_timer.sv
// cp0_timer_irq: timer-interrupt latch plus two-flop interrupt synchroniser.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   int_hw_i[5:0]    asynchronous external interrupt lines
//   cp0_count_i      CP0 Count
//   cp0_compare_i    CP0 Compare
//   wb_cp0_we_i      WB-stage mtc0 write enable
//   wb_cp0_waddr_i   WB-stage mtc0 target register
//   int_o[5:0]       synchronised lines, IP7 merged with the timer latch
module cp0_timer_irq
   import exception_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  int_hw_i,
   input  logic [31:0] cp0_count_i,
   input  logic [31:0] cp0_compare_i,
   input  logic        wb_cp0_we_i,
   input  logic [4:0]  wb_cp0_waddr_i,
   output logic [5:0]  int_o
);

   logic       timer_pend;
   logic [5:0] sync_q;
   logic       compare_wr;
   logic       timer_hit;

   assign compare_wr = wb_cp0_we_i && (wb_cp0_waddr_i == CP0_COMPARE);
   assign timer_hit  = (cp0_count_i == cp0_compare_i) && (cp0_compare_i != '0);

   // A Compare write acknowledges the timer and beats a same-cycle match.
   always_ff @(posedge clk) begin
      if (rst)             timer_pend <= 1'b0;
      else if (compare_wr) timer_pend <= 1'b0;
      else if (timer_hit)  timer_pend <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         int_o  <= '0;
      end else begin
         sync_q <= {int_hw_i[5] | timer_pend, int_hw_i[4:0]};
         int_o  <= sync_q;
      end
   end

endmodule

// File: rtl/exception_ctrl.sv
// exception_ctrl: MEM-stage exception arbiter in front of CP0.
// Picks the highest-priority event for the MEM instruction, drives the
// one-hot excepttype word, EPC source, delay-slot flag and bad address
// to CP0, and issues a registered one-cycle flush with the redirect PC.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   mem_valid_i/pc/delayslot  MEM instruction qualifiers
//   mem_exc_i[7:0]            per-instruction exception flags
//   mem_bad_addr_i            load/store data address
//   cp0_status/cause/epc_i    current CP0 values
//   wb_cp0_we/waddr/data_i    WB-stage mtc0 bypass
//   cp0_count/compare_i       timer inputs
//   int_hw_i[5:0]             external interrupt lines
//   excepttype_o              one-hot event word (0 = none)
//   cur_inst_addr_o, in_delayslot_o, bad_addr_o   CP0 side data
//   int_o[5:0]                synchronised interrupt lines
//   flush_o, new_pc_o         pipeline flush and redirect target
module exception_ctrl
   import exception_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid_i,
   input  logic [31:0] mem_pc_i,
   input  logic        mem_in_delayslot_i,
   input  logic [7:0]  mem_exc_i,
   input  logic [31:0] mem_bad_addr_i,
   input  logic [31:0] cp0_status_i,
   input  logic [31:0] cp0_cause_i,
   input  logic [31:0] cp0_epc_i,
   input  logic        wb_cp0_we_i,
   input  logic [4:0]  wb_cp0_waddr_i,
   input  logic [31:0] wb_cp0_data_i,
   input  logic [31:0] cp0_count_i,
   input  logic [31:0] cp0_compare_i,
   input  logic [5:0]  int_hw_i,
   output logic [31:0] excepttype_o,
   output logic [31:0] cur_inst_addr_o,
   output logic        in_delayslot_o,
   output logic [31:0] bad_addr_o,
   output logic [5:0]  int_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o
);

   state_t      state, state_nx;
   logic        flush_nx;
   logic [31:0] new_pc_nx;
   logic [31:0] status_eff, cause_eff, epc_eff;
   logic        int_pending;

   assign cur_inst_addr_o = mem_pc_i;
   assign in_delayslot_o  = mem_in_delayslot_i;

   // mtc0 still in WB has not reached CP0 yet; forward it.
   always_comb begin
      status_eff = cp0_status_i;
      cause_eff  = cp0_cause_i;
      epc_eff    = cp0_epc_i;
      if (wb_cp0_we_i) begin
         if (wb_cp0_waddr_i == CP0_STATUS) status_eff      = wb_cp0_data_i;
         // only the software-interrupt bits of Cause are writable
         if (wb_cp0_waddr_i == CP0_CAUSE)  cause_eff[9:8]  = wb_cp0_data_i[9:8];
         if (wb_cp0_waddr_i == CP0_EPC)    epc_eff         = wb_cp0_data_i;
      end
   end

   assign int_pending = status_eff[0] && !status_eff[1]
                        && ((cause_eff & status_eff & 32'h0000_FF00) != '0)
                        && mem_valid_i && (state == ST_RUN);

   always_comb begin
      excepttype_o = '0;
      bad_addr_o   = '0;
      if (!rst && state == ST_RUN) begin
         if (int_pending) begin
            excepttype_o[EXC_INT] = 1'b1;
         end else if (mem_valid_i) begin
            if (mem_exc_i[F_ADEL_IF]) begin
               excepttype_o[EXC_ADEL_IF] = 1'b1;
               bad_addr_o                = mem_pc_i;
            end else if (mem_exc_i[F_RI]) begin
               excepttype_o[EXC_RI] = 1'b1;
            end else if (mem_exc_i[F_OV]) begin
               excepttype_o[EXC_OV] = 1'b1;
            end else if (mem_exc_i[F_BREAK]) begin
               excepttype_o[EXC_BREAK] = 1'b1;
            end else if (mem_exc_i[F_SYSCALL]) begin
               excepttype_o[EXC_SYSCALL] = 1'b1;
            end else if (mem_exc_i[F_ADEL_LD]) begin
               excepttype_o[EXC_ADEL_LD] = 1'b1;
               bad_addr_o                = mem_bad_addr_i;
            end else if (mem_exc_i[F_ADES]) begin
               excepttype_o[EXC_ADES] = 1'b1;
               bad_addr_o             = mem_bad_addr_i;
            end else if (mem_exc_i[F_ERET]) begin
               excepttype_o[EXC_ERET] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_nx  = state;
      flush_nx  = 1'b0;
      new_pc_nx = new_pc_o;
      case (state)
         ST_RUN: begin
            if (excepttype_o != '0) begin
               state_nx  = ST_FLUSH;
               flush_nx  = 1'b1;
               new_pc_nx = excepttype_o[EXC_ERET] ? epc_eff : EXC_VECTOR;
            end
         end
         ST_FLUSH: begin
            state_nx = ST_RUN;
         end
         default: begin
            state_nx = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_RUN;
         flush_o  <= 1'b0;
         new_pc_o <= '0;
      end else begin
         state    <= state_nx;
         flush_o  <= flush_nx;
         new_pc_o <= new_pc_nx;
      end
   end

   cp0_timer_irq u_timer_irq (
      .clk            (clk),
      .rst            (rst),
      .int_hw_i       (int_hw_i),
      .cp0_count_i    (cp0_count_i),
      .cp0_compare_i  (cp0_compare_i),
      .wb_cp0_we_i    (wb_cp0_we_i),
      .wb_cp0_waddr_i (wb_cp0_waddr_i),
      .int_o          (int_o)
   );

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl: directed test-plan steps followed
// by randomized cycles, all checked against a priority-table reference model.
module tb_exception_ctrl;

   localparam logic [31:0] VEC = 32'hBFC0_0380;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid_i, mem_in_delayslot_i;
   logic [31:0] mem_pc_i, mem_bad_addr_i;
   logic [7:0]  mem_exc_i;
   logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
   logic        wb_cp0_we_i;
   logic [4:0]  wb_cp0_waddr_i;
   logic [31:0] wb_cp0_data_i, cp0_count_i, cp0_compare_i;
   logic [5:0]  int_hw_i;
   logic [31:0] excepttype_o, cur_inst_addr_o, bad_addr_o, new_pc_o;
   logic        in_delayslot_o, flush_o;
   logic [5:0]  int_o;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // reference model state
   bit          m_flush;
   logic [31:0] m_newpc;
   bit          m_pend;
   logic [5:0]  hist[$];   // [0] = int_o now, [1] = first sync stage

   // priority table, highest first: mem_exc_i flag (-1 = interrupt), output bit
   int prio_flag[9] = '{-1, 0, 1, 2, 3, 4, 5, 6, 7};
   int prio_bit [9] = '{ 0, 13, 10, 16, 9, 8, 14, 15, 12};

   exception_ctrl #(.EXC_VECTOR(VEC)) dut (
      .clk(clk), .rst(rst),
      .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i),
      .mem_in_delayslot_i(mem_in_delayslot_i), .mem_exc_i(mem_exc_i),
      .mem_bad_addr_i(mem_bad_addr_i),
      .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
      .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i),
      .wb_cp0_data_i(wb_cp0_data_i),
      .cp0_count_i(cp0_count_i), .cp0_compare_i(cp0_compare_i),
      .int_hw_i(int_hw_i),
      .excepttype_o(excepttype_o), .cur_inst_addr_o(cur_inst_addr_o),
      .in_delayslot_o(in_delayslot_o), .bad_addr_o(bad_addr_o),
      .int_o(int_o), .flush_o(flush_o), .new_pc_o(new_pc_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] wb_val(input logic [4:0] a, input logic [31:0] cur);
      return (wb_cp0_we_i && wb_cp0_waddr_i == a) ? wb_cp0_data_i : cur;
   endfunction

   // index into the priority table of the winning event, -1 if none
   function automatic int winner();
      logic [31:0] st, ca;
      bit          irq;
      st = wb_val(5'd12, cp0_status_i);
      ca = cp0_cause_i;
      if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) ca[9:8] = wb_cp0_data_i[9:8];
      irq = st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 0);
      if (rst || m_flush || !mem_valid_i) return -1;
      for (int i = 0; i < 9; i++) begin
         if (prio_flag[i] < 0) begin
            if (irq) return i;
         end else if (mem_exc_i[prio_flag[i]]) begin
            return i;
         end
      end
      return -1;
   endfunction

   // one clock: check combinational outputs, advance the model, check registers
   task automatic step(input bit tp = 1'b0, input logic [31:0] tp_exc = '0);
      int          w;
      logic [31:0] e, ba;
      logic [5:0]  v;
      #1;
      w  = winner();
      e  = (w < 0) ? 32'h0 : (32'h1 << prio_bit[w]);
      ba = 32'h0;
      if (w >= 0 && prio_bit[w] == 13) ba = mem_pc_i;
      if (w >= 0 && (prio_bit[w] == 14 || prio_bit[w] == 15)) ba = mem_bad_addr_i;
      chk("excepttype", excepttype_o, e);
      chk("bad_addr", bad_addr_o, ba);
      chk("cur_inst_addr", cur_inst_addr_o, mem_pc_i);
      chk("in_delayslot", {31'h0, in_delayslot_o}, {31'h0, mem_in_delayslot_i});
      if (tp) chk("tp_excepttype", excepttype_o, tp_exc);
      v = {int_hw_i[5] | m_pend, int_hw_i[4:0]};
      @(posedge clk);
      if (rst) begin
         m_flush = 1'b0;
         m_newpc = 32'h0;
         m_pend  = 1'b0;
         hist    = '{6'h0, 6'h0};
      end else begin
         if (m_flush) m_flush = 1'b0;
         else if (e != 0) begin
            m_flush = 1'b1;
            m_newpc = e[12] ? wb_val(5'd14, cp0_epc_i) : VEC;
         end
         if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd11) m_pend = 1'b0;
         else if (cp0_count_i == cp0_compare_i && cp0_compare_i != 0) m_pend = 1'b1;
         void'(hist.pop_front());
         hist.push_back(v);
      end
      #1;
      chk("flush", {31'h0, flush_o}, {31'h0, m_flush});
      chk("new_pc", new_pc_o, m_newpc);
      chk("int_o", {26'h0, int_o}, {26'h0, hist[0]});
   endtask

   task automatic idle_inputs();
      mem_valid_i = 0; mem_in_delayslot_i = 0; mem_pc_i = 32'h8000_0000;
      mem_exc_i = 0; mem_bad_addr_i = 0;
      cp0_status_i = 0; cp0_cause_i = 0; cp0_epc_i = 0;
      wb_cp0_we_i = 0; wb_cp0_waddr_i = 0; wb_cp0_data_i = 0;
      cp0_count_i = 0; cp0_compare_i = 0; int_hw_i = 0;
   endtask

   initial begin
      logic [4:0] waddrs[7] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};
      hist = '{6'h0, 6'h0};
      idle_inputs();
      rst = 1;

      // reset: flags present on a valid instruction must still report nothing
      mem_valid_i = 1; mem_exc_i = 8'hFF;
      step(1'b1, 32'h0);
      step(1'b1, 32'h0);
      chk("rst_flush", {31'h0, flush_o}, 32'h0);
      chk("rst_new_pc", new_pc_o, 32'h0);
      chk("rst_int", {26'h0, int_o}, 32'h0);
      rst = 0;
      idle_inputs();
      step();

      // overflow
      mem_valid_i = 1; mem_exc_i = 8'h04; mem_pc_i = 32'h8000_1000;
      step(1'b1, 32'h0001_0000);
      chk("ov_flush_n1", {31'h0, flush_o}, 32'h1);
      chk("ov_new_pc_n1", new_pc_o, VEC);
      step(1'b1, 32'h0);
      chk("ov_flush_n2", {31'h0, flush_o}, 32'h0);

      // priority: RI beats break
      mem_exc_i = 8'h0A;
      step(1'b1, 32'h0000_0400);
      step();

      // interrupt, then the same with mtc0 Status=0 bypassed from WB
      mem_exc_i = 8'h00; int_hw_i = 6'h01;
      cp0_status_i = 32'h0000_0401; cp0_cause_i = 32'h0000_0400;
      step(1'b1, 32'h0000_0001);
      step();
      wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd12; wb_cp0_data_i = 32'h0;
      step(1'b1, 32'h0);
      idle_inputs();
      step();

      // eret takes the bypassed EPC
      mem_valid_i = 1; mem_exc_i = 8'h80; cp0_epc_i = 32'h8000_0010;
      wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h8000_0200;
      step(1'b1, 32'h0000_1000);
      chk("eret_new_pc", new_pc_o, 32'h8000_0200);
      idle_inputs();
      step();

      // timer: match at count 5, visible on int_o[5] three edges later
      cp0_compare_i = 5;
      cp0_count_i = 5; step();
      cp0_count_i = 6; step();
      chk("timer_early", {31'h0, int_o[5]}, 32'h0);
      cp0_count_i = 7; step();
      chk("timer_set", {31'h0, int_o[5]}, 32'h1);
      wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd11; wb_cp0_data_i = 5;
      cp0_count_i = 8; step();
      wb_cp0_we_i = 0;
      cp0_count_i = 9; step();
      cp0_count_i = 10; step();
      chk("timer_clear", {31'h0, int_o[5]}, 32'h0);
      idle_inputs();

      // reset while the flush is pending
      mem_valid_i = 1; mem_exc_i = 8'h04;
      step(1'b1, 32'h0001_0000);
      rst = 1;
      step(1'b1, 32'h0);
      chk("rstflush_flush", {31'h0, flush_o}, 32'h0);
      rst = 0; mem_valid_i = 0; mem_exc_i = 8'hFF;
      step(1'b1, 32'h0);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         rst                = ($urandom_range(0, 49) == 0);
         mem_valid_i        = $urandom_range(0, 3) != 0;
         mem_in_delayslot_i = 1'($urandom);
         mem_pc_i           = $urandom;
         mem_bad_addr_i     = $urandom;
         mem_exc_i          = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
         cp0_status_i       = $urandom & 32'h0000_FF03;
         cp0_cause_i        = $urandom & 32'h0000_FF00;
         cp0_epc_i          = $urandom;
         wb_cp0_we_i        = 1'($urandom);
         wb_cp0_waddr_i     = waddrs[$urandom_range(0, 6)];
         wb_cp0_data_i      = $urandom;
         cp0_count_i        = $urandom_range(0, 3);
         cp0_compare_i      = $urandom_range(0, 3);
         int_hw_i           = 6'($urandom);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/exception_ctrl.md
# exception_ctrl

Exception arbiter in the MEM stage, upstream of the CP0 register file. It does three things:
- Collects per-instruction exception flags, hardware interrupt lines and the timer compare event.
- Picks the single highest-priority event and drives the one-hot excepttype word, EPC source, delay-slot flag and bad address into CP0.
- Issues a registered one-cycle pipeline flush with the redirect PC, either the exception vector or the EPC for eret.

It also owns the timer-interrupt latch feeding CP0 Cause.IP7.

## Interface
Parameters:
- EXC_VECTOR, 32'hBFC00380, redirect target for every exception and interrupt.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_valid_i  in  1  MEM holds a real (non-bubble) instruction
- mem_pc_i  in  32  PC of the MEM instruction
- mem_in_delayslot_i  in  1  MEM instruction is in a branch delay slot
- mem_exc_i  in  8  flags for the MEM instruction. Bit meanings:
  - [0] fetch AdEL
  - [1] reserved instruction
  - [2] overflow
  - [3] break
  - [4] syscall
  - [5] load AdEL
  - [6] store AdES
  - [7] eret
- mem_bad_addr_i  in  32  data address of the MEM load/store
- cp0_status_i, cp0_cause_i, cp0_epc_i  in  32 each  current CP0 register values
- wb_cp0_we_i  in  1  WB-stage mtc0 write enable
- wb_cp0_waddr_i  in  5  WB-stage mtc0 target register
- wb_cp0_data_i  in  32  WB-stage mtc0 data
- cp0_count_i, cp0_compare_i  in  32 each  Count and Compare values
- int_hw_i  in  6  external interrupt lines, asynchronous
- excepttype_o  out  32  one-hot event word to CP0
- cur_inst_addr_o  out  32  copy of mem_pc_i, to CP0
- in_delayslot_o  out  1  copy of mem_in_delayslot_i, to CP0
- bad_addr_o  out  32  faulting address, to CP0
- int_o  out  6  synchronised interrupt lines, to CP0 int_i
- flush_o  out  1  pipeline flush
- new_pc_o  out  32  redirect target, valid while flush_o=1

## Operation
- **Bypass.** Effective Status is wb_cp0_data_i when wb_cp0_we_i=1 and wb_cp0_waddr_i=12, otherwise cp0_status_i.
  - Effective Cause: the same rule with address 13, but only bits [9:8] are taken from WB.
  - Effective EPC: the same rule with address 14.
- **Interrupt pending.** Requires all of the following:
  - Status[0]=1 and Status[1]=0;
  - (Cause[15:8] & Status[15:8]) != 0, using effective values;
  - mem_valid_i=1 and state RUN.
- **Priority.** Highest first, output bit of excepttype_o in brackets:
  - interrupt [0];
  - fetch AdEL [13];
  - RI [10];
  - Ov [16];
  - break [9];
  - syscall [8];
  - load AdEL [14];
  - store AdES [15];
  - eret [12].
- **Output rule.** Exactly one bit of excepttype_o is set, or none. Flags are ignored unless mem_valid_i=1.
- **bad_addr_o.** mem_pc_i for [13]; mem_bad_addr_i for [14] and [15]; 0 otherwise.
- **Timer latch.** timer_pend is set when cp0_count_i == cp0_compare_i and cp0_compare_i != 0. It is cleared on a WB write to address 11, and the clear wins over a simultaneous set.
- **int_o.** Register {int_hw_i[5] | timer_pend, int_hw_i[4:0]} through two flops.
- **FSM, two states:**
  - RUN → FLUSH when excepttype_o != 0. On that edge register flush_o=1 and new_pc_o: effective EPC for eret, EXC_VECTOR otherwise.
  - FLUSH → RUN unconditionally. On that edge register flush_o=0.
  - In FLUSH, excepttype_o is forced to 0: the MEM instruction is younger and is being flushed.

## Timing
- Exception seen in MEM in cycle N:
  - excepttype_o is asserted combinationally in N, and CP0 commits it at the end of N;
  - flush_o=1 and new_pc_o are valid in N+1 only.
- Back-to-back exceptions are impossible: cycle N+1 always reports 0.
- int_hw_i reaches int_o after 2 cycles.
- timer_pend reaches int_o after 3 cycles: latch plus 2 sync flops.
- Reset values: state RUN, flush_o 0, new_pc_o 0, timer_pend 0, int_o 0. excepttype_o is 0 while rst=1.
- rst asserted while in FLUSH: the next state is RUN with flush_o=0, so no pending redirect survives.
- mtc0 to Status clearing IE in WB in the same cycle as an interrupt condition: the bypass applies, so no interrupt is taken.

## Structure
- Shared package holds:
  - excepttype bit indices (0, 8, 9, 10, 12, 13, 14, 15, 16);
  - CP0 register addresses (8, 9, 11, 12, 13, 14);
  - EXC_VECTOR default;
  - the mem_exc_i field indices.
- One sub-module, `cp0_timer_irq`: owns the timer latch and the 2-flop synchroniser, and outputs int_o.

## Test plan
- **Overflow.** mem_exc_i=8'h04, mem_pc_i=32'h80001000, valid. Expect:
  - excepttype_o=32'h00010000 in N;
  - flush_o=1 with new_pc_o=32'hBFC00380 in N+1;
  - flush_o=0 in N+2.
- **Priority.** mem_exc_i=8'h0A (RI+break) → excepttype_o=32'h00000400 only.
- **Interrupt.** Status=32'h00000401, int_hw_i[0]=1, valid. Expect:
  - excepttype_o=32'h1 once Cause.IP2 is set;
  - in the same case with mtc0 Status=0 in WB in that cycle, excepttype_o=0.
- **eret.** mem_exc_i=8'h80, cp0_epc_i=32'h80000010, WB writing EPC=32'h80000200 → new_pc_o=32'h80000200 in N+1.
- **Timer.** compare=5, count reaches 5 → int_o[5]=1 three cycles later; mtc0 Compare clears it.
- **Reset in FLUSH.** rst in N+1 → flush_o=0 in N+2, excepttype_o=0 throughout, and an invalid MEM with flags set yields 0.
